demux_seq_8: RTL and testbench

- Upstream driver for the 1-to-8 demultiplexer (select inputs S1/S2/S3, data input I).
- Sweeps the 3-bit select through channels 0..7 and holds each channel for a programmable dwell time.
- Gates the data bit onto I only while a sweep is running.
- Supports single-shot or continuous sweeps, abort, and a done pulse. Replaces hand-timed select stimulus with a synthesizable sequencer.

---
 rtl/demux_seq_8_if.sv | 15 +
 rtl/demux_seq_8.sv | 70 +++++++
 tb/tb_demux_seq_8.sv | 130 +++++++++++++
 3 files changed

// File: rtl/demux_seq_8_if.sv
// demux_seq_8_if: control and select/data bundle between a sweep controller and demux_seq_8
interface demux_seq_8_if;
    logic start;
    logic stop;
    logic mode_cont;
    logic data_in;
    logic S1;
    logic S2;
    logic S3;
    logic I;
    logic busy;
    logic done;
    modport master (output start, stop, mode_cont, data_in, input S1, S2, S3, I, busy, done);
    modport slave (input start, stop, mode_cont, data_in, output S1, S2, S3, I, busy, done);
endinterface

// File: rtl/demux_seq_8.sv
// demux_seq_8: sweeps the 1-to-8 demux select through channels 0..7 with a fixed dwell,
// gating data onto I only while a sweep runs
module demux_seq_8 #(
    parameter int DWELL = 100,
    parameter int CW = 7
) (
    input logic clk,
    input logic rst,
    demux_seq_8_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    state_t state;
    logic [2:0] chan;
    logic [CW-1:0] cnt;
    assign {bus.S3, bus.S2, bus.S1} = chan;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            chan <= '0;
            cnt <= '0;
            bus.I <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.I <= bus.start & bus.data_in;
                    bus.busy <= bus.start;
                    chan <= '0;
                    cnt <= '0;
                    if (bus.start) state <= RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state <= IDLE;
                        chan <= '0;
                        cnt <= '0;
                        bus.I <= 1'b0;
                        bus.busy <= 1'b0;
                    end else if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                        bus.I <= bus.data_in;
                    end else begin
                        cnt <= '0;
                        // channel 7 expiry ends a single sweep with select held at 7
                        if (chan == 3'd7 && !bus.mode_cont) begin
                            state <= DONE;
                            bus.I <= 1'b0;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            chan <= chan + 3'd1;
                            bus.I <= bus.data_in;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    chan <= '0;
                    cnt <= '0;
                    bus.I <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_demux_seq_8.sv
// tb_demux_seq_8: three sequencers (DWELL 4, 2, 1) on shared stimulus, checked every cycle
// against a sweep-position model
module tb_demux_seq_8;
    logic clk = 1'b0;
    logic rst, start, stop, mode_cont, data_in;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int dw[3] = '{4, 2, 1};
    int ph[3];
    int pos[3];
    logic mi[3];
    int fd[3];
    int t0;
    logic [5:0] o[3];
    always #5 clk = ~clk;
    demux_seq_8_if ifa ();
    demux_seq_8_if ifb ();
    demux_seq_8_if ifc ();
    assign {ifa.start, ifa.stop, ifa.mode_cont, ifa.data_in} = {start, stop, mode_cont, data_in};
    assign {ifb.start, ifb.stop, ifb.mode_cont, ifb.data_in} = {start, stop, mode_cont, data_in};
    assign {ifc.start, ifc.stop, ifc.mode_cont, ifc.data_in} = {start, stop, mode_cont, data_in};
    assign o[0] = {ifa.S3, ifa.S2, ifa.S1, ifa.I, ifa.busy, ifa.done};
    assign o[1] = {ifb.S3, ifb.S2, ifb.S1, ifb.I, ifb.busy, ifb.done};
    assign o[2] = {ifc.S3, ifc.S2, ifc.S1, ifc.I, ifc.busy, ifc.done};
    demux_seq_8 #(.DWELL(4), .CW(3)) u0 (.clk(clk), .rst(rst), .bus(ifa.slave));
    demux_seq_8 #(.DWELL(2), .CW(2)) u1 (.clk(clk), .rst(rst), .bus(ifb.slave));
    demux_seq_8 #(.DWELL(1), .CW(1)) u2 (.clk(clk), .rst(rst), .bus(ifc.slave));
    function automatic logic [5:0] expv(int n);
        logic [2:0] s;
        s = ph[n] == 1 ? 3'((pos[n] / dw[n]) % 8) : ph[n] == 2 ? 3'd7 : 3'd0;
        return {s, mi[n], ph[n] == 1, ph[n] == 2};
    endfunction
    task automatic chk(string tag, logic [31:0] a, logic [31:0] e);
        vectors++;
        assert (a === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, a, e, cyc);
        end
    endtask
    // ph: 0 idle, 1 running, 2 done; pos counts RUN cycles since the sweep began
    task automatic step();
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            if (rst) begin
                ph[n] = 0; pos[n] = 0; mi[n] = 1'b0;
            end else if (ph[n] == 0) begin
                ph[n] = start ? 1 : 0; pos[n] = 0; mi[n] = start & data_in;
            end else if (ph[n] == 1) begin
                if (stop) begin
                    ph[n] = 0; pos[n] = 0; mi[n] = 1'b0;
                end else if (pos[n] % (8 * dw[n]) == 8 * dw[n] - 1 && !mode_cont) begin
                    ph[n] = 2; mi[n] = 1'b0;
                end else begin
                    pos[n]++; mi[n] = data_in;
                end
            end else begin
                ph[n] = 0; pos[n] = 0; mi[n] = 1'b0;
            end
        end
        #1;
        cyc++;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("out%0d", n), 32'(o[n]), 32'(expv(n)));
            if (o[n][0] && fd[n] < 0) fd[n] = cyc - t0;
        end
    endtask
    initial begin
        for (int n = 0; n < 3; n++) begin
            ph[n] = 0; pos[n] = 0; mi[n] = 1'b0; fd[n] = -1;
        end
        t0 = 0;
        {rst, start, stop, mode_cont, data_in} = 5'b10000;
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0; data_in = 1'b1;
        repeat (3) step();
        chk("idle_gate", 32'(o[0]), 32'h0);
        // single sweep with start pulses landing in RUN and in DONE
        t0 = cyc;
        start = 1'b1; step(); start = 1'b0;
        repeat (8) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (22) step();
        step();
        chk("done_sel7", 32'(o[0]), 32'b111001);
        start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        chk("done_d4", fd[0], 33);
        chk("done_d2", fd[1], 17);
        chk("done_d1", fd[2], 9);
        // reset mid-sweep at channel 3
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (12) step();
        chk("pre_rst_sel3", 32'(o[0][5:3]), 32'd3);
        rst = 1'b1; repeat (2) step(); rst = 1'b0;
        chk("rst_out", 32'(o[0]), 32'h0);
        repeat (4) step();
        chk("rst_idle", 32'(o[0]), 32'h0);
        // continuous sweeps with toggling data, then fall back to single
        mode_cont = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            data_in = ~data_in; step();
        end
        chk("cont_busy", 32'(o[1][1]), 32'd1);
        mode_cont = 1'b0;
        for (int k = 0; k < 40 && (o[0][1] || o[0][0]); k++) step();
        chk("cont_end", 32'(o[0]), 32'h0);
        // abort at channel 5, last dwell cycle
        rst = 1'b1; step(); rst = 1'b0; data_in = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        repeat (23) step();
        chk("abort_pre", 32'(o[0]), 32'b101110);
        stop = 1'b1; step(); stop = 1'b0;
        chk("abort", 32'(o[0]), 32'h0);
        repeat (3) step();
        for (int k = 0; k < 2000; k++) begin
            rst = $urandom_range(0, 199) == 0;
            start = $urandom_range(0, 9) == 0;
            stop = $urandom_range(0, 59) == 0;
            mode_cont = $urandom_range(0, 3) != 0;
            data_in = 1'($urandom);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
